preg_free_list: RTL

- Allocator for the 64-entry physical register file used by the rename stage.
- Keeps the free physical register tags in a circular FIFO.
- Hands one free tag per cycle to rename (allocate port) and accepts one retired tag per cycle back from commit (release port).
- Rename stalls when the block reports no free tag.

---
 rtl/preg_free_list_pkg.sv | 8 +
 rtl/fl_ring_buf.sv | 40 ++++
 rtl/preg_free_list.sv | 56 +++++
 3 files changed

// File: rtl/preg_free_list_pkg.sv
// preg_free_list_pkg: physical register file sizing shared by rename-stage blocks.
package preg_free_list_pkg;
  localparam int NUM_PREGS = 64;
  localparam int NUM_AREGS = 32;
  localparam int PREG_W = $clog2(NUM_PREGS);
  localparam int FL_DEPTH = NUM_PREGS - NUM_AREGS;
  typedef logic [PREG_W-1:0] preg_t;
endpackage

// File: rtl/fl_ring_buf.sv
// fl_ring_buf: circular FIFO that comes out of reset full, holding INIT_BASE..INIT_BASE+DEPTH-1.
module fl_ring_buf #(
  parameter int W = 6,
  parameter int DEPTH = 32,
  parameter int INIT_BASE = 0,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     dout,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] head, tail;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign dout = mem[head];
  assign empty = count == '0;
  assign full = count == CNT_W'(DEPTH);
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      count <= CNT_W'(DEPTH);
      for (int i = 0; i < DEPTH; i++) mem[i] <= W'(INIT_BASE + i);
    end else begin
      head <= pop ? nxt(head) : head;
      tail <= push ? nxt(tail) : tail;
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (push) mem[tail] <= din;
    end
  end
endmodule

// File: rtl/preg_free_list.sv
// preg_free_list: free physical tag allocator for rename; one grant and one release per cycle.
// Define PREG_DOUBLE_FREE_CHECK_EN to reject releases of tags already in the list.
module preg_free_list
  import preg_free_list_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          alloc_req,
  output logic          alloc_gnt,
  output preg_t         alloc_preg,
  input  logic          rel_valid,
  input  preg_t         rel_preg,
  output logic [PREG_W:0] free_count,
  output logic          empty,
  output logic          full,
  output logic          err
);
  logic rel_nz, overflow, dup, push;
  fl_ring_buf #(
    .W(PREG_W),
    .DEPTH(FL_DEPTH),
    .INIT_BASE(NUM_AREGS),
    .CNT_W(PREG_W + 1)
  ) u_ring (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(alloc_gnt),
    .din(rel_preg),
    .dout(alloc_preg),
    .count(free_count),
    .empty(empty),
    .full(full)
  );
  assign alloc_gnt = alloc_req & ~empty;
  // p0 is hard-wired to x0 and must never re-enter the pool
  assign rel_nz = rel_valid && rel_preg != '0;
  assign overflow = rel_nz & full & ~alloc_gnt;
  assign push = rel_nz & ~overflow & ~dup;
`ifdef PREG_DOUBLE_FREE_CHECK_EN
  logic [NUM_PREGS-1:0] in_list;
  // a same-cycle grant of the same tag removes it first, so that release is legal
  assign dup = rel_nz && in_list[rel_preg] && !(alloc_gnt && alloc_preg == rel_preg);
  always_ff @(posedge clk) begin
    if (rst) in_list <= {{FL_DEPTH{1'b1}}, {NUM_AREGS{1'b0}}};
    else in_list <= (in_list & ~(alloc_gnt ? NUM_PREGS'(1) << alloc_preg : '0))
                    | (push ? NUM_PREGS'(1) << rel_preg : '0);
  end
`else
  assign dup = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else err <= err | overflow | dup;
  end
endmodule
